// File: rtl/idli_alu_m.sv
// Nibble-serial 16-bit ALU: four cycles per operation, LSB nibble first, registered {N,Z,C}.
// Optional macro IDLI_ALU_CARRY_IN_EN: ADC/SBC take flag C as the nibble-0 carry-in.
module idli_alu_m (
  input  logic       i_alu_gck,
  input  logic       i_alu_rst,
  input  logic       i_alu_start,
  input  logic [2:0] i_alu_op,
  input  logic       i_alu_wr_req,
  output logic       o_alu_ready,
  input  logic [3:0] i_alu_lhs_data,
  input  logic [3:0] i_alu_rhs_data,
  output logic       o_alu_wr_en,
  output logic [3:0] o_alu_wr_data,
  output logic       o_alu_done,
  output logic [2:0] o_alu_flags
);

  typedef enum logic {StIdle, StRun} state_e;

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpSub  = 3'd1;
  localparam logic [2:0] OpAnd  = 3'd2;
  localparam logic [2:0] OpOr   = 3'd3;
  localparam logic [2:0] OpXor  = 3'd4;
  localparam logic [2:0] OpAndn = 3'd5;
  localparam logic [2:0] OpAdc  = 3'd6;
  localparam logic [2:0] OpSbc  = 3'd7;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic [2:0] op_q, op_d;
  logic       wr_req_q, wr_req_d;
  logic [2:0] flags_q, flags_d;

  logic       run;
  logic       last;
  logic       accept;
  logic       sub_op;
  logic       cin0;
  logic       cin;
  logic [3:0] rhs_eff;
  logic [4:0] sum;
  logic [3:0] res;
  logic       cout;
  logic       zero_acc;

  always_comb begin
    run    = (state_q == StRun);
    last   = run && (cnt_q == 2'd3);
    accept = i_alu_start && (!run || last);
    sub_op = (op_q == OpSub) || (op_q == OpSbc);

`ifdef IDLI_ALU_CARRY_IN_EN
    cin0 = ((op_q == OpAdc) || (op_q == OpSbc)) ? flags_q[0] : sub_op;
`else
    cin0 = sub_op;
`endif

    cin     = (cnt_q == 2'd0) ? cin0 : carry_q;
    rhs_eff = sub_op ? ~i_alu_rhs_data : i_alu_rhs_data;
    sum     = {1'b0, i_alu_lhs_data} + {1'b0, rhs_eff} + {4'b0000, cin};

    res  = sum[3:0];
    cout = sum[4];
    case (op_q)
      OpAnd: begin
        res  = i_alu_lhs_data & i_alu_rhs_data;
        cout = 1'b0;
      end
      OpOr: begin
        res  = i_alu_lhs_data | i_alu_rhs_data;
        cout = 1'b0;
      end
      OpXor: begin
        res  = i_alu_lhs_data ^ i_alu_rhs_data;
        cout = 1'b0;
      end
      OpAndn: begin
        res  = i_alu_lhs_data & ~i_alu_rhs_data;
        cout = 1'b0;
      end
      default: ;
    endcase

    // Z accumulates across nibbles; nibble 0 starts a fresh operation.
    zero_acc = (res == 4'h0) && ((cnt_q == 2'd0) || zero_q);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    op_d     = op_q;
    wr_req_d = wr_req_q;
    flags_d  = flags_q;

    if (run) begin
      cnt_d   = cnt_q + 2'd1;
      carry_d = cout;
      zero_d  = zero_acc;
      if (last) begin
        state_d = StIdle;
        flags_d = {res[3], zero_acc, cout};
      end
    end

    if (accept) begin
      state_d  = StRun;
      cnt_d    = 2'd0;
      op_d     = i_alu_op;
      wr_req_d = i_alu_wr_req;
    end
  end

  always_ff @(posedge i_alu_gck or posedge i_alu_rst) begin
    if (i_alu_rst) begin
      state_q  <= StIdle;
      cnt_q    <= 2'd0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      op_q     <= 3'd0;
      wr_req_q <= 1'b0;
      flags_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      op_q     <= op_d;
      wr_req_q <= wr_req_d;
      flags_q  <= flags_d;
    end
  end

  assign o_alu_ready   = !run || last;
  assign o_alu_wr_en   = run && wr_req_q;
  assign o_alu_wr_data = run ? res : 4'h0;
  assign o_alu_done    = last;
  assign o_alu_flags   = flags_q;

endmodule

// File: tb/tb_idli_alu_m.sv
// Directed bench for idli_alu_m: per-nibble results, strobes, flags, chaining and reset abort.
module tb_idli_alu_m;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic       wr_req;
  logic       ready;
  logic [3:0] lhs;
  logic [3:0] rhs;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       done;
  logic [2:0] flags;

  int n_checks = 0;
  int n_pass   = 0;

  idli_alu_m u_dut (
    .i_alu_gck      (clk),
    .i_alu_rst      (rst),
    .i_alu_start    (start),
    .i_alu_op       (op),
    .i_alu_wr_req   (wr_req),
    .o_alu_ready    (ready),
    .i_alu_lhs_data (lhs),
    .i_alu_rhs_data (rhs),
    .o_alu_wr_en    (wr_en),
    .o_alu_wr_data  (wr_data),
    .o_alu_done     (done),
    .o_alu_flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic start_op(input logic [2:0] o, input logic wr);
    @(posedge clk);
    #1;
    start  = 1'b1;
    op     = o;
    wr_req = wr;
  endtask

  // Feeds four nibbles and checks each cycle; hold keeps start high and presents the next op.
  task automatic run_nibbles(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp, input logic exp_wr, input logic hold,
                             input logic [2:0] next_op, input logic next_wr,
                             input logic chk_prev, input logic [2:0] prev_flags);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 && chk_prev) check_eq({tag, "_prevflags"}, {13'd0, flags}, {13'd0, prev_flags});
      start = hold;
      if (hold) begin
        op     = next_op;
        wr_req = next_wr;
      end
      lhs = a[4*k +: 4];
      rhs = b[4*k +: 4];
      @(negedge clk);
      check_eq($sformatf("%s_data%0d", tag, k), {12'd0, wr_data}, {12'd0, exp[4*k +: 4]});
      check_eq($sformatf("%s_wren%0d", tag, k), {15'd0, wr_en}, {15'd0, exp_wr});
      check_eq($sformatf("%s_done%0d", tag, k), {15'd0, done}, {15'd0, (k == 3)});
      check_eq($sformatf("%s_rdy%0d", tag, k), {15'd0, ready}, {15'd0, (k == 3)});
    end
  endtask

  task automatic finish_op(input string tag, input logic [2:0] exp_flags);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, "_flags"}, {13'd0, flags}, {13'd0, exp_flags});
    check_eq({tag, "_idle"}, {11'd0, ready, done, wr_en, 2'b00}, {11'd0, 1'b1, 1'b0, 1'b0, 2'b00});
    check_eq({tag, "_idledata"}, {12'd0, wr_data}, 16'd0);
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic wr,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp,
                       input logic [2:0] exp_flags);
    start_op(o, wr);
    run_nibbles(tag, a, b, exp, wr, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    finish_op(tag, exp_flags);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    op     = 3'd0;
    wr_req = 1'b0;
    lhs    = 4'h0;
    rhs    = 4'h0;
    #1;
    check_eq("rst_ready", {15'd0, ready}, 16'd1);
    check_eq("rst_wren", {15'd0, wr_en}, 16'd0);
    check_eq("rst_wdata", {12'd0, wr_data}, 16'd0);
    check_eq("rst_done", {15'd0, done}, 16'd0);
    check_eq("rst_flags", {13'd0, flags}, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    do_op("add1", 3'd0, 1'b1, 16'h1234, 16'h0FCD, 16'h2201, 3'b000);
    do_op("add2", 3'd0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 3'b011);
    do_op("or", 3'd3, 1'b1, 16'h0000, 16'h0000, 16'h0000, 3'b010);
    do_op("andn", 3'd5, 1'b1, 16'hFFFF, 16'h0F0F, 16'hF0F0, 3'b100);
    do_op("cmp", 3'd1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 3'b011);
    do_op("sub", 3'd1, 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 3'b100);

    // AND then XOR with start held: the XOR is accepted on the AND done cycle.
    start_op(3'd2, 1'b1);
    run_nibbles("and", 16'hF0F0, 16'h3C3C, 16'h3030, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 3'd0);
    run_nibbles("xor", 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'b000);
    finish_op("xor", 3'b100);

    // Reset during nibble 1 of an ADD.
    start_op(3'd0, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    lhs   = 4'h1;
    rhs   = 4'h1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("abort_pre_wren", {15'd0, wr_en}, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_wren", {15'd0, wr_en}, 16'd0);
    check_eq("abort_ready", {15'd0, ready}, 16'd1);
    check_eq("abort_flags", {13'd0, flags}, 16'd0);
    check_eq("abort_done", {15'd0, done}, 16'd0);
    check_eq("abort_wdata", {12'd0, wr_data}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("abort_quiet%0d", i), {14'd0, done, wr_en}, 16'd0);
    end
    check_eq("abort_flags_hold", {13'd0, flags}, 16'd0);

    do_op("add3", 3'd0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 3'b011);
`ifdef IDLI_ALU_CARRY_IN_EN
    do_op("adc", 3'd6, 1'b1, 16'h0000, 16'h0000, 16'h0001, 3'b000);
    do_op("sbc", 3'd7, 1'b1, 16'h0005, 16'h0003, 16'h0001, 3'b001);
`else
    do_op("adc", 3'd6, 1'b1, 16'h0000, 16'h0000, 16'h0000, 3'b010);
    do_op("sbc", 3'd7, 1'b1, 16'h0005, 16'h0003, 16'h0002, 3'b001);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/idli_alu_m.md
IDLI_ALU_M -- requirements
Module: idli_alu_m

Interface
REQ-001 SHALL have port i_alu_gck  input  1  clock; the single clock, all state on its rising edge.
REQ-002 SHALL have port i_alu_rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have port i_alu_start  input  1  request to begin a 16b operation.
REQ-004 SHALL have port i_alu_op  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ANDN (lhs & ~rhs), 6 ADC, 7 SBC.
REQ-005 SHALL have port i_alu_wr_req  input  1  result is written back; 0 means flags only (e.g. SUB as compare).
REQ-006 SHALL have port o_alu_ready  output  1  start is accepted this cycle if i_alu_start=1.
REQ-007 SHALL have port i_alu_lhs_data  input  4  current LHS nibble from the register file read port.
REQ-008 SHALL have port i_alu_rhs_data  input  4  current RHS nibble from the register file read port.
REQ-009 SHALL have port o_alu_wr_en  output  1  write enable to the register file write port.
REQ-010 SHALL have port o_alu_wr_data  output  4  result nibble to the register file write port.
REQ-011 SHALL have port o_alu_done  output  1  final (fourth) result nibble is being produced this cycle.
REQ-012 SHALL have port o_alu_flags  output  3  registered {N,Z,C} of the last completed operation.

Function
REQ-013 SHALL implement states IDLE and RUN, with a 2b nibble counter valid in RUN.
REQ-014 o_alu_ready SHALL be 1 in IDLE and in RUN when the counter is 3; otherwise 0.
REQ-015 Start acceptance (i_alu_start & o_alu_ready) SHALL latch op and wr_req, enter RUN, and set the counter to 0 in the next cycle.
REQ-016 In RUN, nibble k (k = counter, LSB first) SHALL be computed combinationally from the same-cycle lhs/rhs nibbles and the carry register.
REQ-017 Counter SHALL increment each RUN cycle; at 3 it SHALL return to IDLE unless a new start is accepted, in which case RUN continues at 0 with no bubble.
REQ-018 o_alu_wr_en SHALL be 1 only in RUN with latched wr_req=1; o_alu_wr_data SHALL be 0 outside RUN.
REQ-019 ADD SHALL use carry-in 0 at nibble 0; SUB SHALL add ~rhs with carry-in 1; the carry register SHALL hold the 4b carry-out between nibbles.
REQ-020 Logic ops SHALL produce carry-out 0.
REQ-021 o_alu_done SHALL be 1 exactly in RUN with counter 3.
REQ-022 Flags SHALL update on the done cycle edge: C = final carry-out (SUB: 1 = no borrow), Z = all four result nibbles zero, N = bit 3 of nibble 3.
REQ-023 Flags SHALL update regardless of wr_req and SHALL hold otherwise.
REQ-024 i_alu_start while o_alu_ready=0 SHALL be ignored with no state change.

Reset
REQ-025 Reset SHALL force IDLE, counter 0, carry 0, latched op 0, wr_req 0, flags 3'b000.
REQ-026 During reset: o_alu_ready=1, o_alu_wr_en=0, o_alu_wr_data=0, o_alu_done=0, o_alu_flags=0.
REQ-027 Reset mid-operation SHALL abandon the operation with no further wr_en and no flag update.

Configuration
REQ-028 Macro IDLI_ALU_CARRY_IN_EN defined: ADC/SBC SHALL use flag C as the nibble-0 carry-in (SBC with ~rhs).
REQ-029 Macro IDLI_ALU_CARRY_IN_EN undefined: op 6 SHALL behave as ADD and op 7 as SUB; flag C SHALL not affect results.

Verification
REQ-030 ADD 0x1234+0x0FCD, wr_req=1 -> wr_data 1,0,2,2 over four cycles with wr_en=1, done on 4th; flags N=0,Z=0,C=0.
REQ-031 ADD 0xFFFF+0x0001 -> wr_data 0,0,0,0; flags N=0,Z=1,C=1.
REQ-032 SUB 0x0005-0x0005 with wr_req=0 -> wr_en=0 for all four cycles; flags N=0,Z=1,C=1; SUB 0x0003-0x0005 -> flags N=1,Z=0,C=0.
REQ-033 Start held high with AND then XOR back-to-back (second start on done cycle) -> eight consecutive RUN cycles, no bubble, done pulses on cycles 4 and 8.
REQ-034 Reset asserted at counter 1 of an ADD -> wr_en drops in the same cycle, ready=1, flags 000, no done pulse.
REQ-035 With IDLI_ALU_CARRY_IN_EN, ADD 0xFFFF+0x0001 then ADC 0x0000+0x0000 -> result 0x0001; without it -> result 0x0000.
